// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, byte-strobed synchronous memory between the
// instruction-fetch port (I) and the load/store port (D). At most one
// request is granted per cycle. A small tag FIFO records the owner of every
// in-flight read, so each memory read response is steered back to the port
// that issued it.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   i_req/i_addr -> i_gnt          instruction read request / accept
//   i_rvalid/i_rdata               instruction read response
//   d_req/d_we/d_addr/d_wdata/
//   d_wstrb -> d_gnt               data request / accept
//   d_rvalid/d_rdata               data read response
//   m_ready/m_we/m_addr/m_wdata/
//   m_wstrb                        memory request strobe and fields
//   m_rresp/m_rdata                memory read response
module mem_port_arbiter #(
  parameter bit          D_PRIO      = 1'b1,
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [29:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_ready,
  output logic        m_we,
  output logic [29:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_rresp,
  input  logic [31:0] m_rdata
);

  localparam int         PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int         CNT_W = $clog2(OUTSTANDING + 1);
  localparam logic [3:0] SMAX  = 4'(STARVE_MAX);

  // Owner tags: 0 = I-port, 1 = D-port.
  logic [OUTSTANDING-1:0] tags;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [3:0]             i_starve, d_starve;

  logic blocked, empty, head;
  logic i_elig, d_elig, pick_i, pick_d;
  logic push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    // Depth is a power of two, so the pointer wraps on its own; a depth of
    // one keeps the pointer pinned at zero.
    if (OUTSTANDING == 1) ptr_inc = '0;
    else                  ptr_inc = p + PTR_W'(1);
  endfunction

  always_comb begin
    blocked = (count == CNT_W'(OUTSTANDING));
    empty   = (count == '0);
    head    = tags[rd_ptr];

    // Writes produce no response, so a full tag FIFO never stalls them.
    i_elig  = i_req & ~blocked;
    d_elig  = d_req & (d_we | ~blocked);

    pick_i  = 1'b0;
    pick_d  = 1'b0;
    if (i_elig && d_elig) begin
      if (d_starve == SMAX)      pick_d = 1'b1;
      else if (i_starve == SMAX) pick_i = 1'b1;
      else if (D_PRIO)           pick_d = 1'b1;
      else                       pick_i = 1'b1;
    end else begin
      pick_i = i_elig;
      pick_d = d_elig;
    end

    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    m_ready = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    if (!reset) begin
      i_gnt   = pick_i;
      d_gnt   = pick_d;
      m_ready = pick_i | pick_d;
      if (pick_d) begin
        m_we    = d_we;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        m_wstrb = d_we ? d_wstrb : 4'h0;
      end else if (pick_i) begin
        m_addr  = i_addr;
      end
    end

    // A response with no outstanding tag is stale and dropped.
    pop      = m_rresp & ~empty & ~reset;
    push     = i_gnt | (d_gnt & ~d_we);
    i_rvalid = pop & ~head;
    d_rvalid = pop & head;
    i_rdata  = m_rdata;
    d_rdata  = m_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tags     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      i_starve <= '0;
      d_starve <= '0;
    end else begin
      if (push) begin
        tags[wr_ptr] <= d_gnt;
        wr_ptr       <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // A port only ages while it is eligible and loses to the other port.
      if (i_gnt)                                      i_starve <= '0;
      else if (i_elig && pick_d && i_starve != SMAX)  i_starve <= i_starve + 4'd1;
      if (d_gnt)                                      d_starve <= '0;
      else if (d_elig && pick_i && d_starve != SMAX)  d_starve <= d_starve + 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [29:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_ready, m_we;
  logic [29:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_rresp;
  logic [31:0] m_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.D_PRIO(1'b1), .STARVE_MAX(4), .OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_ready(m_ready), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rresp(m_rresp), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later,
  // well clear of the rising edge that updates state.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_wstrb = '0; m_rresp = 0; m_rdata = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    // Reset forces all outputs low even with live requests and a response.
    step(); reset = 1; i_req = 1; i_addr = 30'h10; d_req = 1; d_addr = 30'h20; m_rresp = 1;
    #1;
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_m_ready", m_ready, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_m_addr", m_addr, 0);

    // Idle for 10 cycles.
    step(); reset = 0; idle_inputs();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      #1;
      chk("idle_m_ready", m_ready, 0);
      chk("idle_gnt", {i_gnt, d_gnt}, 0);
    end
    chk("idle_i_starve", dut.i_starve, 0);
    chk("idle_d_starve", dut.d_starve, 0);

    // Single I read.
    step(); i_req = 1; i_addr = 30'h10;
    #1;
    chk("i1_gnt", i_gnt, 1);
    chk("i1_m_ready", m_ready, 1);
    chk("i1_m_we", m_we, 0);
    chk("i1_m_addr", m_addr, 32'h10);
    chk("i1_m_wstrb", m_wstrb, 0);
    step(); i_req = 0; m_rresp = 1; m_rdata = 32'hDEADBEEF;
    #1;
    chk("i1_rvalid", i_rvalid, 1);
    chk("i1_rdata", i_rdata, 32'hDEADBEEF);
    chk("i1_d_rvalid", d_rvalid, 0);

    // Interleaved reads: I@0x4 then D@0x8, responses in order.
    step(); m_rresp = 0; i_req = 1; i_addr = 30'h4;
    #1;
    chk("il_i_gnt", i_gnt, 1);
    step(); i_req = 0; d_req = 1; d_we = 0; d_addr = 30'h8;
    #1;
    chk("il_d_gnt", d_gnt, 1);
    chk("il_d_addr", m_addr, 32'h8);
    step(); d_req = 0; m_rresp = 1; m_rdata = 32'h11111111;
    #1;
    chk("il_r1_i_rvalid", i_rvalid, 1);
    chk("il_r1_d_rvalid", d_rvalid, 0);
    step(); m_rdata = 32'h22222222;
    #1;
    chk("il_r2_d_rvalid", d_rvalid, 1);
    chk("il_r2_i_rvalid", i_rvalid, 0);
    chk("il_r2_d_rdata", d_rdata, 32'h22222222);
    // Stale response with nothing outstanding is dropped.
    step(); m_rdata = 32'h33333333;
    #1;
    chk("stale_rvalid", {i_rvalid, d_rvalid}, 0);
    chk("stale_count", dut.count, 0);

    // Fill the FIFO with two D reads, then a write still gets through.
    step(); m_rresp = 0; d_req = 1; d_we = 0; d_addr = 30'h20;
    #1;
    chk("full_rd1_gnt", d_gnt, 1);
    step(); d_addr = 30'h21;
    #1;
    chk("full_rd2_gnt", d_gnt, 1);
    step(); d_we = 1; d_addr = 30'h22; d_wdata = 32'hCAFE; d_wstrb = 4'h3; i_req = 1; i_addr = 30'h30;
    #1;
    chk("full_wr_gnt", d_gnt, 1);
    chk("full_wr_m_we", m_we, 1);
    chk("full_wr_wstrb", m_wstrb, 32'h3);
    chk("full_wr_wdata", m_wdata, 32'hCAFE);
    chk("full_i_blocked", i_gnt, 0);
    step(); d_req = 0; d_we = 0; d_wstrb = 0;
    #1;
    chk("full_i_held", i_gnt, 0);
    chk("full_i_starve_hold", dut.i_starve, 0);
    // First response pops, but the count seen this cycle is still full.
    step(); m_rresp = 1; m_rdata = 32'hA0A0A0A0;
    #1;
    chk("full_r1_d_rvalid", d_rvalid, 1);
    chk("full_r1_i_gnt", i_gnt, 0);
    step(); m_rdata = 32'hA1A1A1A1;
    #1;
    chk("full_r2_d_rvalid", d_rvalid, 1);
    chk("full_r2_i_gnt", i_gnt, 1);
    chk("full_r2_m_addr", m_addr, 32'h30);
    step(); i_req = 0; m_rdata = 32'hB0B0B0B0;
    #1;
    chk("full_r3_i_rvalid", i_rvalid, 1);
    chk("full_r3_d_rvalid", d_rvalid, 0);

    // Tie: both request every cycle (D writes, I reads). D wins 4, I wins 1.
    step(); m_rresp = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      i_req = 1; i_addr = 30'h100 + 30'(k);
      d_req = 1; d_we = 1; d_addr = 30'h200; d_wdata = 32'h5A5A0000 + k; d_wstrb = 4'hF;
      m_rresp = (k == 5); m_rdata = 32'h0000BEEF;
      #1;
      chk("tie_i_gnt", i_gnt, (k % 5 == 4) ? 1 : 0);
      chk("tie_d_gnt", d_gnt, (k % 5 == 4) ? 0 : 1);
      if (k == 4) chk("tie_i_starve_max", dut.i_starve, 4);
      if (k == 5) begin
        chk("tie_i_starve_clr", dut.i_starve, 0);
        chk("tie_d_starve_one", dut.d_starve, 1);
        chk("tie_i_rvalid", i_rvalid, 1);
      end
    end
    step(); idle_inputs(); m_rresp = 1;
    #1;
    chk("tie_drain_i_rvalid", i_rvalid, 1);

    // Reset mid-flight discards the outstanding tag.
    step(); m_rresp = 0; d_req = 1; d_we = 0; d_addr = 30'h40;
    #1;
    chk("rmf_d_gnt", d_gnt, 1);
    step(); reset = 1; d_req = 0;
    #1;
    chk("rmf_rst_m_ready", m_ready, 0);
    step(); reset = 0; m_rresp = 1; m_rdata = 32'h77777777;
    #1;
    chk("rmf_no_rvalid", {i_rvalid, d_rvalid}, 0);
    chk("rmf_count", dut.count, 0);
    step(); m_rresp = 0; i_req = 1; i_addr = 30'h50;
    #1;
    chk("rmf_i_gnt", i_gnt, 1);
    chk("rmf_m_addr", m_addr, 32'h50);
    step(); i_req = 0; m_rresp = 1; m_rdata = 32'h12345678;
    #1;
    chk("rmf_i_rvalid", i_rvalid, 1);
    chk("rmf_i_rdata", i_rdata, 32'h12345678);

    step(); idle_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
